// File: rtl/pc_redirect_unit_pkg.sv
// pc_redirect_unit_pkg: redirect FSM states and branch funct3 encodings
package pc_redirect_unit_pkg;
   typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;
   localparam logic [2:0] BEQ  = 3'b000;
   localparam logic [2:0] BNE  = 3'b001;
   localparam logic [2:0] BLT  = 3'b100;
   localparam logic [2:0] BGE  = 3'b101;
   localparam logic [2:0] BLTU = 3'b110;
   localparam logic [2:0] BGEU = 3'b111;
endpackage

// File: rtl/pc_redirect_unit_branch_cond.sv
// pc_redirect_unit_branch_cond: resolves branch taken from funct3 and ALU flags
module pc_redirect_unit_branch_cond
   import pc_redirect_unit_pkg::*;
(
   input  logic [2:0] funct3,
   input  logic       zero,
   input  logic       lsb,
   output logic       taken
);
   always_comb begin
      taken = (funct3 == BEQ)                     ? zero  :
              (funct3 == BNE)                     ? !zero :
              (funct3 == BLT || funct3 == BLTU)   ? lsb   :
              (funct3 == BGE || funct3 == BGEU)   ? !lsb  : 1'b0;
   end
endmodule

// File: rtl/pc_redirect_unit.sv
// pc_redirect_unit: fetch PC register, branch/jump redirect FSM, flush counter and misaligned-target trap
module pc_redirect_unit
   import pc_redirect_unit_pkg::*;
#(
   parameter int                    DATA_WIDTH   = 32,
   parameter logic [DATA_WIDTH-1:0] RESET_VECTOR = 32'h0000_0000,
   parameter logic [DATA_WIDTH-1:0] TRAP_VECTOR  = 32'h0000_0100,
   parameter int                    FLUSH_CYCLES = 2
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  stall,
   input  logic                  valid_ex,
   input  logic                  branch,
   input  logic                  jump,
   input  logic                  jalr,
   input  logic [2:0]            funct3,
   input  logic                  zero,
   input  logic [DATA_WIDTH-1:0] aluresult,
   input  logic [DATA_WIDTH-1:0] immext,
   input  logic [DATA_WIDTH-1:0] pc_ex,
   input  logic                  trap_ack,
   output logic [DATA_WIDTH-1:0] pc,
   output logic [DATA_WIDTH-1:0] pc_plus4,
   output logic                  flush,
   output logic                  trap
);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);
   state_t                  state;
   logic [CW-1:0]           cnt;
   logic                    taken, redirect, misaligned;
   logic [DATA_WIDTH-1:0]   target;
   pc_redirect_unit_branch_cond u_cond (
      .funct3 (funct3),
      .zero   (zero),
      .lsb    (aluresult[0]),
      .taken  (taken)
   );
   always_comb begin
      redirect   = valid_ex & (jump | (branch & taken));
      target     = jalr ? {aluresult[DATA_WIDTH-1:1], 1'b0} : pc_ex + immext;
      misaligned = target[1];
      pc_plus4   = pc + DATA_WIDTH'(4);
      flush      = (state == FLUSH);
      trap       = (state == TRAP);
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc    <= RESET_VECTOR;
         state <= RUN;
         cnt   <= '0;
      end else begin
         case (state)
            RUN: if (!stall) begin
               if (redirect && misaligned) begin
                  pc    <= TRAP_VECTOR;
                  state <= TRAP;
               end else if (redirect) begin
                  pc    <= target;
                  cnt   <= CW'(FLUSH_CYCLES - 1);
                  state <= FLUSH;
               end else
                  pc <= pc_plus4;
            end
            FLUSH: if (!stall) begin
               pc <= pc_plus4;
               if (cnt == '0) state <= RUN;
               else           cnt   <= cnt - 1'b1;
            end
            TRAP: if (trap_ack) state <= RUN;
            default: state <= RUN;
         endcase
      end
   end
endmodule
